// File: rtl/intpol2_d4_fd_eval_pkg.sv
// Shared definitions for the second-order forward-difference evaluator:
// state encoding, sample-width helper and sign extension.
package intpol2_D4_pkg;

   // Two-state control: waiting for a coefficient set, or emitting its samples
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   // Widest value the sign-extension helper can handle
   localparam int SEXT_MAX_W = 64;

   // Sample width W = fractional bits + integer bits
   function automatic int sample_width(input int data_width, input int n_bits);
      return data_width + n_bits;
   endfunction

   // Sign-extend the low from_w bits of v to SEXT_MAX_W bits; callers cast
   // the result down to their accumulator width
   function automatic logic [SEXT_MAX_W-1:0] sext(input logic [SEXT_MAX_W-1:0] v,
                                                  input int from_w);
      logic [SEXT_MAX_W-1:0] mask;
      logic                  sign_bit;
      mask     = {SEXT_MAX_W{1'b1}} << from_w;
      sign_bit = v[6'(from_w - 1)];
      if (sign_bit) begin
         return v | mask;
      end else begin
         return v & ~mask;
      end
   endfunction

endpackage

// File: rtl/intpol2_d4_fd_eval_sat.sv
// fit(): narrows an accumulator value to sample width.
// Build option INTPOL2_D4_SAT_EN: defined -> saturate to the signed OUT_W
// range; undefined -> keep the low OUT_W bits (two's-complement wrap).
module intpol2_D4_sat #(
   parameter int IN_W  = 14,
   parameter int OUT_W = 10
) (
   input  logic [IN_W-1:0]  i_in,
   output logic [OUT_W-1:0] o_out
);
   import intpol2_D4_pkg::*;

`ifdef INTPOL2_D4_SAT_EN
   // Bits that must all equal the sign for the value to fit in OUT_W
   logic [IN_W-OUT_W:0] w_hi;
   assign w_hi = i_in[IN_W-1:OUT_W-1];

   // Clamp to the most negative / most positive sample when out of range
   always_comb begin
      o_out = i_in[OUT_W-1:0];
      if ((w_hi == {(IN_W-OUT_W+1){1'b0}}) || (w_hi == {(IN_W-OUT_W+1){1'b1}})) begin
         o_out = i_in[OUT_W-1:0];
      end else if (i_in[IN_W-1]) begin
         o_out = {1'b1, {(OUT_W-1){1'b0}}};
      end else begin
         o_out = {1'b0, {(OUT_W-1){1'b1}}};
      end
   end
`else
   // Plain truncation: upper guard bits are dropped
   assign o_out = OUT_W'(i_in);
`endif

endmodule

// File: rtl/intpol2_d4_fd_eval.sv
// Forward-difference evaluator: takes (p0, d1, d2) and emits L = 2^LOG2_L
// samples by double accumulation. Output narrowing is selected by the
// build macro INTPOL2_D4_SAT_EN (see intpol2_D4_sat).
module intpol2_d4_fd_eval #(
   parameter int DATA_WIDTH = 32,
   parameter int N_bits     = 2,
   parameter int LOG2_L     = 2,
   parameter int GUARD      = 4,
   localparam int W         = intpol2_D4_pkg::sample_width(DATA_WIDTH, N_bits)
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         en,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] p0,
   input  logic [W-1:0] d1,
   input  logic [W-1:0] d2,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] y,
   output logic         out_last
);
   import intpol2_D4_pkg::*;

   localparam int                AW       = W + GUARD;
   localparam logic [LOG2_L-1:0] CNT_LAST = LOG2_L'((1 << LOG2_L) - 1);
   localparam logic [LOG2_L-1:0] CNT_ONE  = LOG2_L'(1);

   logic [0:0]        r_state;
   logic [AW-1:0]     r_y_acc;
   logic [AW-1:0]     r_d1_acc;
   logic [W-1:0]      r_d2_reg;
   logic [LOG2_L-1:0] r_cnt;

   logic          w_run;
   logic          w_last;
   logic          w_in_ready;
   logic          w_in_hs;
   logic          w_out_hs;
   logic [AW-1:0] w_p0_ext;
   logic [AW-1:0] w_d1_ext;
   logic [AW-1:0] w_d2_ext;
   logic [W-1:0]  w_fit;

   assign w_run    = (r_state == ST_RUN);
   assign w_last   = (r_cnt == CNT_LAST);
   assign w_p0_ext = AW'(sext(SEXT_MAX_W'(p0), W));
   assign w_d1_ext = AW'(sext(SEXT_MAX_W'(d1), W));
   assign w_d2_ext = AW'(sext(SEXT_MAX_W'(r_d2_reg), W));

   // A new set is accepted when idle, or on the final beat of the current
   // set as it is consumed, so consecutive sets run without a bubble
   assign w_in_ready = rstn & en & (~w_run | (w_last & out_ready));
   assign w_in_hs    = w_in_ready & in_valid;
   assign w_out_hs   = rstn & en & w_run & out_ready;

   assign in_ready  = w_in_ready;
   assign out_valid = rstn & en & w_run;
   assign out_last  = rstn & w_run & w_last;
   assign y         = rstn ? w_fit : {W{1'b0}};

   intpol2_D4_sat #(
      .IN_W  (AW),
      .OUT_W (W)
   ) u_sat (
      .i_in  (r_y_acc),
      .o_out (w_fit)
   );

   // Control and accumulator update; en low freezes everything
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state  <= ST_IDLE;
         r_y_acc  <= {AW{1'b0}};
         r_d1_acc <= {AW{1'b0}};
         r_d2_reg <= {W{1'b0}};
         r_cnt    <= {LOG2_L{1'b0}};
      end else if (w_in_hs) begin
         r_state  <= ST_RUN;
         r_y_acc  <= w_p0_ext;
         r_d1_acc <= w_d1_ext;
         r_d2_reg <= d2;
         r_cnt    <= {LOG2_L{1'b0}};
      end else if (w_out_hs) begin
         if (w_last) begin
            r_state <= ST_IDLE;
         end else begin
            r_y_acc  <= r_y_acc + r_d1_acc;
            r_d1_acc <= r_d1_acc + w_d2_ext;
            r_cnt    <= r_cnt + CNT_ONE;
         end
      end else begin
         r_state <= r_state;
      end
   end

endmodule
